// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: machine word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Arbiter state encoding; raw codes kept alongside the enum for legacy tools.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IFETCH = 2'd1;
  localparam logic [1:0] ST_DACC   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    IFETCH = ST_IFETCH,
    DACC   = ST_DACC
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and shared RAM port bundle for mem_arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      halt;
  word_t     ramload;
  ramstate_t ramstate;
  word_t     ramaddr;
  word_t     ramstore;
  logic      ramREN;
  logic      ramWEN;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      busy;
  logic      err;

  // slave: the arbiter; master: the core + RAM environment around it
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output ramaddr, ramstore, ramREN, ramWEN, iwait, dwait, iload, dload, busy, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    input  ramaddr, ramstore, ramREN, ramWEN, iwait, dwait, iload, dload, busy, err
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Grant wait counter: saturating up-count while a grant stalls, timeout on the
// cycle that would reach MAX_WAIT so the grant lasts exactly MAX_WAIT cycles.
module mem_arb_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam int unsigned   CW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] TOP  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count <= '0;
    end else if (count_en && (count != TOP)) begin
      count <= count + CW'(1);
    end
  end

  assign timeout = count_en && (count >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single RAM port: data over fetch, with optional
// fetch anti-starvation when MEM_ARB_FAIR_EN is defined.
//
//   state  | meaning
//   IDLE   | no grant; picks the next requester (one bubble between grants)
//   IFETCH | RAM driven with the fetch address
//   DACC   | RAM driven with the data read/write
module mem_arbiter
  import cpu_types_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  mem_arb_state_t state, state_next;
  logic ireq, dreq, fetch_ok, in_grant, withdraw, access, ram_err;
  logic i_done, d_done, fault, timeout, count_en, starve_hit, err_flag;

  assign ireq     = bus.iREN;
  assign dreq     = bus.dREN | bus.dWEN;
  assign fetch_ok = bus.iREN & ~bus.halt;
  assign in_grant = (state != IDLE);
  assign access   = (bus.ramstate == ACCESS);
  assign ram_err  = (bus.ramstate == ERROR);
  assign withdraw = ((state == IFETCH) && !ireq) || ((state == DACC) && !dreq);

  // reset in the same cycle as ACCESS aborts the transfer instead of completing it
  assign i_done   = (state == IFETCH) && ireq && access && !RST;
  assign d_done   = (state == DACC)   && dreq && access && !RST;
  assign count_en = in_grant && !withdraw && !access && !ram_err;

  mem_arb_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (state == IDLE),
    .count_en (count_en),
    .timeout  (timeout)
  );

  always_comb begin
    state_next = state;
    fault      = 1'b0;
    case (state)
      IDLE: begin
        if (starve_hit)    state_next = IFETCH;
        else if (dreq)     state_next = DACC;
        else if (fetch_ok) state_next = IFETCH;
      end
      IFETCH, DACC: begin
        if (withdraw || access) begin
          state_next = IDLE;
        end else if (ram_err || timeout) begin
          state_next = IDLE;
          fault      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      err_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (fault) err_flag <= 1'b1;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned   SW     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] S_LIM  = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve;

  assign starve_hit = (state == IDLE) && fetch_ok && (starve >= S_LIM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve <= '0;
    end else if ((state == IDLE) && (state_next == IFETCH)) begin
      starve <= '0;
    end else if ((state == IDLE) && (state_next == DACC) && fetch_ok && (starve != S_LIM)) begin
      starve <= starve + SW'(1);
    end
  end
`else
  logic unused_starve_limit;

  assign starve_hit          = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
`endif

  always_comb begin
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    case (state)
      IFETCH: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
      end
      DACC: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
      end
      default: ;
    endcase
  end

  assign bus.iwait = ireq && !i_done;
  assign bus.dwait = dreq && !d_done;
  assign bus.iload = i_done ? bus.ramload : '0;
  assign bus.dload = d_done ? bus.ramload : '0;
  assign bus.busy  = in_grant;
  assign bus.err   = err_flag;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: cycles a grant may wait for ACCESS before timeout.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch waits (fair mode only).
REQ-003 SHALL have ports CLK in 1: clock, all state on rising edge; RST in 1: synchronous, active-high reset.
REQ-004 SHALL have iREN in 1 (fetch request), iaddr in 32 (fetch address).
REQ-005 SHALL have dREN in 1, dWEN in 1 (data read/write request), daddr in 32, dstore in 32 (store data).
REQ-006 SHALL have halt in 1: core halted; blocks new fetch grants.
REQ-007 SHALL have ramload in 32 (RAM read data), ramstate in ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-008 SHALL have ramaddr out 32, ramstore out 32, ramREN out 1, ramWEN out 1 (shared RAM port).
REQ-009 SHALL have iwait out 1, dwait out 1 (low = access completes this cycle), iload out 32, dload out 32.
REQ-010 SHALL have busy out 1 (state not IDLE), err out 1 (sticky fault flag).

Function
REQ-011 SHALL implement FSM states IDLE, IFETCH, DACC; state registered, RAM outputs decoded combinationally from state.
REQ-012 IDLE: dREN|dWEN pending -> DACC; else iREN & !halt -> IFETCH; else stay IDLE (data priority).
REQ-013 IDLE SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-014 IFETCH SHALL drive ramaddr=iaddr, ramREN=1, ramWEN=0.
REQ-015 DACC SHALL drive ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN; dWEN wins if both set (ramREN=0).
REQ-016 Completion: in IFETCH/DACC with ramstate==ACCESS, corresponding wait SHALL be 0 that cycle, iload/dload=ramload that cycle, next state IDLE.
REQ-017 iwait SHALL be 1 whenever iREN=1 and not completing; dwait likewise for dREN|dWEN; both 0 with no request.
REQ-018 Latency: request sampled in IDLE cycle t; RAM driven from t+1; earliest completion t+1; one IDLE bubble between back-to-back grants.
REQ-019 Withdrawal: requester drops its REN/WEN mid-grant -> return to IDLE next cycle, no completion, no err.
REQ-020 ramstate==ERROR in a grant state -> IDLE next cycle, err set, wait held high that cycle.
REQ-021 Wait counter: cleared on grant, +1 per grant-state cycle without ACCESS; reaching MAX_WAIT -> IDLE, err set.
REQ-022 Counter SHALL saturate, never wrap; width clog2(MAX_WAIT+1).
REQ-023 halt mid-IFETCH SHALL let that fetch complete; data grants unaffected by halt.
REQ-024 iload/dload SHALL be 0 when not completing.

Reset
REQ-025 RST=1 at edge: state=IDLE, wait counter=0, starve counter=0, err=0; outputs then per IDLE (iwait/dwait follow REQ-017).
REQ-026 RST mid-grant SHALL abort access without completion; RST dominates all other inputs.

Configuration
REQ-027 Macro MEM_ARB_FAIR_EN defined: starve counter +1 per data grant while iREN & !halt pending, cleared on fetch grant; at STARVE_LIMIT, IDLE grants IFETCH over data.
REQ-028 MEM_ARB_FAIR_EN undefined: strict data priority, no starve counter logic.

Structure
REQ-029 Enum mem_arb_state_t (IDLE, IFETCH, DACC) SHALL live in shared package mem_arb_pkg; ramstate_t, word_t from cpu_types_pkg.
REQ-030 Wait counter + timeout compare SHALL be sub-module mem_arb_timer (CLK, RST, clear, count_en, timeout out).

Verification
REQ-031 iREN=1, iaddr=0x40, ACCESS on 2nd grant cycle, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 from t+1; iwait=0, iload=0xDEADBEEF at t+2; IDLE at t+3.
REQ-032 iREN and dWEN both set in IDLE, daddr=0x100, dstore=0x12345678 -> DACC first, ramWEN=1, ramREN=0; IFETCH after completion + one bubble.
REQ-033 ramstate BUSY forever, MAX_WAIT=15 -> IDLE after 15 grant cycles, err=1, stays 1 until RST.
REQ-034 dREN dropped after 2 BUSY cycles -> IDLE next cycle, dwait never 0, err=0.
REQ-035 MEM_ARB_FAIR_EN, STARVE_LIMIT=4, dREN and iREN held high -> exactly 4 DACC grants then 1 IFETCH; undefined -> IFETCH never granted.
REQ-036 RST asserted in DACC with ramstate=ACCESS same cycle -> IDLE next cycle, counters 0, err=0, iREN grant possible from the following cycle.
